// File: rtl/id_ex_stage_if.sv
// ID/EX stage bundle: decoded operands and control from ID, forwarding
// taps from MEM/WB, and the registered/forwarded outputs toward EX.
interface id_ex_stage_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int SEL_WIDTH      = 3,
  parameter int REG_ADDR_WIDTH = 5
);
  // Pipeline control
  logic                      i_stall;
  logic                      i_flush;

  // Decoded instruction from ID
  logic                      i_valid;
  logic [DATA_WIDTH-1:0]     i_rs1_data;
  logic [DATA_WIDTH-1:0]     i_rs2_data;
  logic [DATA_WIDTH-1:0]     i_imm;
  logic [REG_ADDR_WIDTH-1:0] i_rs1_addr;
  logic [REG_ADDR_WIDTH-1:0] i_rs2_addr;
  logic [REG_ADDR_WIDTH-1:0] i_rd_addr;
  logic [SEL_WIDTH-1:0]      i_alu_sel;
  logic                      i_alu_src_imm;
  logic                      i_reg_write;
  logic                      i_mem_write;
  logic                      i_mem_to_reg;

  // Forwarding taps
  logic                      i_mem_fwd_we;
  logic [REG_ADDR_WIDTH-1:0] i_mem_fwd_rd;
  logic [DATA_WIDTH-1:0]     i_mem_fwd_data;
  logic                      i_wb_fwd_we;
  logic [REG_ADDR_WIDTH-1:0] i_wb_fwd_rd;
  logic [DATA_WIDTH-1:0]     i_wb_fwd_data;

  // Toward EX / EX-MEM / hazard unit
  logic                      o_valid;
  logic [DATA_WIDTH-1:0]     o_src_a;
  logic [DATA_WIDTH-1:0]     o_src_b;
  logic [SEL_WIDTH-1:0]      o_alu_sel;
  logic [DATA_WIDTH-1:0]     o_store_data;
  logic [REG_ADDR_WIDTH-1:0] o_rs1_addr;
  logic [REG_ADDR_WIDTH-1:0] o_rs2_addr;
  logic [REG_ADDR_WIDTH-1:0] o_rd_addr;
  logic                      o_reg_write;
  logic                      o_mem_write;
  logic                      o_mem_to_reg;

  // Upstream side (ID, hazard unit, MEM/WB taps) drives the i_* signals
  modport master (
    output i_stall, i_flush, i_valid, i_rs1_data, i_rs2_data, i_imm,
           i_rs1_addr, i_rs2_addr, i_rd_addr, i_alu_sel, i_alu_src_imm,
           i_reg_write, i_mem_write, i_mem_to_reg,
           i_mem_fwd_we, i_mem_fwd_rd, i_mem_fwd_data,
           i_wb_fwd_we, i_wb_fwd_rd, i_wb_fwd_data,
    input  o_valid, o_src_a, o_src_b, o_alu_sel, o_store_data,
           o_rs1_addr, o_rs2_addr, o_rd_addr, o_reg_write, o_mem_write,
           o_mem_to_reg
  );

  // The ID/EX stage itself
  modport slave (
    input  i_stall, i_flush, i_valid, i_rs1_data, i_rs2_data, i_imm,
           i_rs1_addr, i_rs2_addr, i_rd_addr, i_alu_sel, i_alu_src_imm,
           i_reg_write, i_mem_write, i_mem_to_reg,
           i_mem_fwd_we, i_mem_fwd_rd, i_mem_fwd_data,
           i_wb_fwd_we, i_wb_fwd_rd, i_wb_fwd_data,
    output o_valid, o_src_a, o_src_b, o_alu_sel, o_store_data,
           o_rs1_addr, o_rs2_addr, o_rd_addr, o_reg_write, o_mem_write,
           o_mem_to_reg
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding feeding the ALU.
// Update priority per edge: reset > flush (bubble) > stall (hold) > load.
module id_ex_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int SEL_WIDTH      = 3,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic          i_clk,
  input  logic          i_rst,
  id_ex_stage_if.slave  bus
);

  typedef enum logic [1:0] {
    UPD_LOAD   = 2'd0,
    UPD_HOLD   = 2'd1,
    UPD_BUBBLE = 2'd2
  } upd_mode_e;

  upd_mode_e upd_mode;

  logic                      valid_q,       valid_d;
  logic [DATA_WIDTH-1:0]     rs1_data_q,    rs1_data_d;
  logic [DATA_WIDTH-1:0]     rs2_data_q,    rs2_data_d;
  logic [DATA_WIDTH-1:0]     imm_q,         imm_d;
  logic [REG_ADDR_WIDTH-1:0] rs1_addr_q,    rs1_addr_d;
  logic [REG_ADDR_WIDTH-1:0] rs2_addr_q,    rs2_addr_d;
  logic [REG_ADDR_WIDTH-1:0] rd_addr_q,     rd_addr_d;
  logic [SEL_WIDTH-1:0]      alu_sel_q,     alu_sel_d;
  logic                      alu_src_imm_q, alu_src_imm_d;
  logic                      reg_write_q,   reg_write_d;
  logic                      mem_write_q,   mem_write_d;
  logic                      mem_to_reg_q,  mem_to_reg_d;

  logic [DATA_WIDTH-1:0]     fwd_a;
  logic [DATA_WIDTH-1:0]     fwd_b;
  logic                      mem_hit_a, wb_hit_a;
  logic                      mem_hit_b, wb_hit_b;

  // Hazard-unit controls collapse into one update mode; flush beats stall
  always_comb begin
    upd_mode = UPD_LOAD;
    if (bus.i_flush) begin
      upd_mode = UPD_BUBBLE;
    end else if (bus.i_stall) begin
      upd_mode = UPD_HOLD;
    end
  end

  // Forward from MEM first, then WB, matching on the registered sources; x0 never matches
  always_comb begin
    mem_hit_a = bus.i_mem_fwd_we && (bus.i_mem_fwd_rd != '0) && (bus.i_mem_fwd_rd == rs1_addr_q);
    wb_hit_a  = bus.i_wb_fwd_we  && (bus.i_wb_fwd_rd  != '0) && (bus.i_wb_fwd_rd  == rs1_addr_q);
    mem_hit_b = bus.i_mem_fwd_we && (bus.i_mem_fwd_rd != '0) && (bus.i_mem_fwd_rd == rs2_addr_q);
    wb_hit_b  = bus.i_wb_fwd_we  && (bus.i_wb_fwd_rd  != '0) && (bus.i_wb_fwd_rd  == rs2_addr_q);

    fwd_a = rs1_data_q;
    if (mem_hit_a) begin
      fwd_a = bus.i_mem_fwd_data;
    end else if (wb_hit_a) begin
      fwd_a = bus.i_wb_fwd_data;
    end

    fwd_b = rs2_data_q;
    if (mem_hit_b) begin
      fwd_b = bus.i_mem_fwd_data;
    end else if (wb_hit_b) begin
      fwd_b = bus.i_wb_fwd_data;
    end
  end

  // Next-state selection for every stage field
  always_comb begin
    valid_d       = valid_q;
    rs1_data_d    = rs1_data_q;
    rs2_data_d    = rs2_data_q;
    imm_d         = imm_q;
    rs1_addr_d    = rs1_addr_q;
    rs2_addr_d    = rs2_addr_q;
    rd_addr_d     = rd_addr_q;
    alu_sel_d     = alu_sel_q;
    alu_src_imm_d = alu_src_imm_q;
    reg_write_d   = reg_write_q;
    mem_write_d   = mem_write_q;
    mem_to_reg_d  = mem_to_reg_q;

    unique case (upd_mode)
      UPD_BUBBLE: begin
        valid_d       = 1'b0;
        rs1_data_d    = '0;
        rs2_data_d    = '0;
        imm_d         = '0;
        rs1_addr_d    = '0;
        rs2_addr_d    = '0;
        rd_addr_d     = '0;
        alu_sel_d     = '0;
        alu_src_imm_d = 1'b0;
        reg_write_d   = 1'b0;
        mem_write_d   = 1'b0;
        mem_to_reg_d  = 1'b0;
      end
      UPD_HOLD: begin
        // Capture forwarded operands so a producer leaving WB during the stall is kept
        rs1_data_d = fwd_a;
        rs2_data_d = fwd_b;
      end
      UPD_LOAD: begin
        valid_d       = bus.i_valid;
        rs1_data_d    = bus.i_rs1_data;
        rs2_data_d    = bus.i_rs2_data;
        imm_d         = bus.i_imm;
        rs1_addr_d    = bus.i_rs1_addr;
        rs2_addr_d    = bus.i_rs2_addr;
        rd_addr_d     = bus.i_rd_addr;
        alu_sel_d     = bus.i_alu_sel;
        alu_src_imm_d = bus.i_alu_src_imm;
        reg_write_d   = bus.i_reg_write;
        mem_write_d   = bus.i_mem_write;
        mem_to_reg_d  = bus.i_mem_to_reg;
      end
      default: begin
      end
    endcase
  end

  // Stage register with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q       <= 1'b0;
      rs1_data_q    <= '0;
      rs2_data_q    <= '0;
      imm_q         <= '0;
      rs1_addr_q    <= '0;
      rs2_addr_q    <= '0;
      rd_addr_q     <= '0;
      alu_sel_q     <= '0;
      alu_src_imm_q <= 1'b0;
      reg_write_q   <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_to_reg_q  <= 1'b0;
    end else begin
      valid_q       <= valid_d;
      rs1_data_q    <= rs1_data_d;
      rs2_data_q    <= rs2_data_d;
      imm_q         <= imm_d;
      rs1_addr_q    <= rs1_addr_d;
      rs2_addr_q    <= rs2_addr_d;
      rd_addr_q     <= rd_addr_d;
      alu_sel_q     <= alu_sel_d;
      alu_src_imm_q <= alu_src_imm_d;
      reg_write_q   <= reg_write_d;
      mem_write_q   <= mem_write_d;
      mem_to_reg_q  <= mem_to_reg_d;
    end
  end

  // Output drive: ALU sources, store data and registered control
  always_comb begin
    bus.o_valid      = valid_q;
    bus.o_src_a      = fwd_a;
    bus.o_src_b      = alu_src_imm_q ? imm_q : fwd_b;
    bus.o_alu_sel    = alu_sel_q;
    bus.o_store_data = fwd_b;
    bus.o_rs1_addr   = rs1_addr_q;
    bus.o_rs2_addr   = rs2_addr_q;
    bus.o_rd_addr    = rd_addr_q;
    bus.o_reg_write  = reg_write_q;
    bus.o_mem_write  = mem_write_q;
    bus.o_mem_to_reg = mem_to_reg_q;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed cases followed by random traffic against a
// record-level reference of the stage contents.
module tb_id_ex_stage;

  logic clk = 1'b0;
  logic rst;

  id_ex_stage_if #(.DATA_WIDTH(32), .SEL_WIDTH(3), .REG_ADDR_WIDTH(5)) bus ();

  id_ex_stage #(.DATA_WIDTH(32), .SEL_WIDTH(3), .REG_ADDR_WIDTH(5)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Contents of the stage as the reference sees them
  typedef struct {
    logic        valid;
    logic [31:0] rs1_data, rs2_data, imm;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic [2:0]  sel;
    logic        src_imm, reg_write, mem_write, mem_to_reg;
  } stage_t;

  stage_t m;
  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  // Operand value seen through the bypass network for register r
  function automatic logic [31:0] ref_fwd(input logic [4:0] r, input logic [31:0] held);
    if (bus.i_mem_fwd_we && r != 0 && bus.i_mem_fwd_rd == r) return bus.i_mem_fwd_data;
    if (bus.i_wb_fwd_we  && r != 0 && bus.i_wb_fwd_rd  == r) return bus.i_wb_fwd_data;
    return held;
  endfunction

  // Apply one clock edge to the reference using the inputs present now
  task automatic ref_edge();
    stage_t n;
    n = m;
    if (rst || bus.i_flush) begin
      n = '{default: '0};
    end else if (bus.i_stall) begin
      n.rs1_data = ref_fwd(m.rs1_addr, m.rs1_data);
      n.rs2_data = ref_fwd(m.rs2_addr, m.rs2_data);
    end else begin
      n.valid = bus.i_valid;        n.rs1_data = bus.i_rs1_data;
      n.rs2_data = bus.i_rs2_data;  n.imm = bus.i_imm;
      n.rs1_addr = bus.i_rs1_addr;  n.rs2_addr = bus.i_rs2_addr;
      n.rd_addr = bus.i_rd_addr;    n.sel = bus.i_alu_sel;
      n.src_imm = bus.i_alu_src_imm; n.reg_write = bus.i_reg_write;
      n.mem_write = bus.i_mem_write; n.mem_to_reg = bus.i_mem_to_reg;
    end
    m = n;
  endtask

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare every output against the reference
  task automatic check_all(input string tag);
    logic [31:0] fa, fb;
    fa = ref_fwd(m.rs1_addr, m.rs1_data);
    fb = ref_fwd(m.rs2_addr, m.rs2_data);
    cmp({tag, ".valid"},      32'(bus.o_valid),      32'(m.valid));
    cmp({tag, ".src_a"},      bus.o_src_a,           fa);
    cmp({tag, ".src_b"},      bus.o_src_b,           m.src_imm ? m.imm : fb);
    cmp({tag, ".alu_sel"},    32'(bus.o_alu_sel),    32'(m.sel));
    cmp({tag, ".store_data"}, bus.o_store_data,      fb);
    cmp({tag, ".rs1_addr"},   32'(bus.o_rs1_addr),   32'(m.rs1_addr));
    cmp({tag, ".rs2_addr"},   32'(bus.o_rs2_addr),   32'(m.rs2_addr));
    cmp({tag, ".rd_addr"},    32'(bus.o_rd_addr),    32'(m.rd_addr));
    cmp({tag, ".reg_write"},  32'(bus.o_reg_write),  32'(m.reg_write));
    cmp({tag, ".mem_write"},  32'(bus.o_mem_write),  32'(m.mem_write));
    cmp({tag, ".mem_to_reg"}, 32'(bus.o_mem_to_reg), 32'(m.mem_to_reg));
  endtask

  task automatic tick();
    ref_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] imm, input logic [4:0] a1, input logic [4:0] a2,
                        input logic [4:0] rd, input logic [2:0] sel, input logic si,
                        input logic rw, input logic mw, input logic m2r);
    bus.i_valid = v;       bus.i_rs1_data = d1;  bus.i_rs2_data = d2;  bus.i_imm = imm;
    bus.i_rs1_addr = a1;   bus.i_rs2_addr = a2;  bus.i_rd_addr = rd;   bus.i_alu_sel = sel;
    bus.i_alu_src_imm = si; bus.i_reg_write = rw; bus.i_mem_write = mw; bus.i_mem_to_reg = m2r;
  endtask

  task automatic set_fwd(input logic mwe, input logic [4:0] mrd, input logic [31:0] md,
                         input logic wwe, input logic [4:0] wrd, input logic [31:0] wd);
    bus.i_mem_fwd_we = mwe; bus.i_mem_fwd_rd = mrd; bus.i_mem_fwd_data = md;
    bus.i_wb_fwd_we  = wwe; bus.i_wb_fwd_rd  = wrd; bus.i_wb_fwd_data  = wd;
  endtask

  initial begin
    m = '{default: '0};
    rst = 1'b0;
    bus.i_stall = 1'b0;
    bus.i_flush = 1'b0;
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    set_id(1'b1, 32'h1234, 32'h5678, 32'h9, 5'd3, 5'd4, 5'd5, 3'b011, 1'b1, 1'b1, 1'b1, 1'b1);
    #2;

    // 1: reset with nonzero inputs
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all("reset");
    cmp("reset.valid_const", 32'(bus.o_valid), 32'h0);
    cmp("reset.src_a_const", bus.o_src_a, 32'h0);

    // 2: register operands, sub
    set_id(1'b1, 32'd5, 32'd7, 32'h0, 5'd1, 5'd2, 5'd6, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    check_all("load_reg");
    cmp("load_reg.src_a_const", bus.o_src_a, 32'd5);
    cmp("load_reg.src_b_const", bus.o_src_b, 32'd7);

    // 3: immediate B, store data still rs2
    set_id(1'b1, 32'd1, 32'd9, 32'hFFFF_FFFC, 5'd1, 5'd2, 5'd0, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    check_all("load_imm");
    cmp("load_imm.src_b_const", bus.o_src_b, 32'hFFFF_FFFC);
    cmp("load_imm.store_const", bus.o_store_data, 32'd9);

    // 4: forwarding priority on rs1 = x3
    set_id(1'b1, 32'd1, 32'd2, 32'h0, 5'd3, 5'd0, 5'd7, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    set_fwd(1'b1, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB);
    #1 check_all("fwd_mem");
    cmp("fwd_mem.src_a_const", bus.o_src_a, 32'hAA);
    set_fwd(1'b0, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB);
    #1 check_all("fwd_wb");
    cmp("fwd_wb.src_a_const", bus.o_src_a, 32'hBB);
    set_fwd(1'b1, 5'd0, 32'hAA, 1'b1, 5'd0, 32'hBB);
    #1 check_all("fwd_x0");
    cmp("fwd_x0.src_a_const", bus.o_src_a, 32'd1);

    // 5: stall keeps a WB result that is only visible in the first stall cycle
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    set_id(1'b1, 32'h10, 32'h20, 32'h0, 5'd4, 5'd5, 5'd8, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    bus.i_stall = 1'b1;
    set_id(1'b1, 32'hDEAD, 32'hBEEF, 32'h77, 5'd9, 5'd10, 5'd11, 3'b100, 1'b1, 1'b0, 1'b1, 1'b1);
    set_fwd(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h55);
    #1 check_all("stall_c1");
    cmp("stall_c1.src_a_const", bus.o_src_a, 32'h55);
    tick();
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1 check_all("stall_c2");
    cmp("stall_c2.src_a_const", bus.o_src_a, 32'h55);
    cmp("stall_c2.rs1_addr_const", 32'(bus.o_rs1_addr), 32'd4);
    tick();
    bus.i_stall = 1'b0;
    #1 check_all("stall_rel");
    cmp("stall_rel.src_a_const", bus.o_src_a, 32'h55);
    tick();
    check_all("stall_load");
    cmp("stall_load.src_a_const", bus.o_src_a, 32'hDEAD);

    // 6: flush beats stall
    bus.i_stall = 1'b1;
    bus.i_flush = 1'b1;
    tick();
    bus.i_stall = 1'b0;
    bus.i_flush = 1'b0;
    check_all("flush_stall");
    cmp("flush_stall.valid_const", 32'(bus.o_valid), 32'h0);
    cmp("flush_stall.reg_write_const", 32'(bus.o_reg_write), 32'h0);

    // Random traffic over a small register window so bypass hits are frequent
    for (int i = 0; i < 400; i++) begin
      set_id($urandom_range(0, 1), $urandom, $urandom, $urandom,
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
             3'($urandom_range(0, 4)), $urandom_range(0, 1), $urandom_range(0, 1),
             $urandom_range(0, 1), $urandom_range(0, 1));
      set_fwd($urandom_range(0, 1), 5'($urandom_range(0, 3)), $urandom,
              $urandom_range(0, 1), 5'($urandom_range(0, 3)), $urandom);
      bus.i_stall = ($urandom_range(0, 3) == 0);
      bus.i_flush = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 49) == 0);
      #1 check_all("rand_pre");
      tick();
      rst = 1'b0;
      check_all("rand_post");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
